// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit that steps the DataPath
// through fetch (T0-T2) and execute (T3-T6) one state per clock.
// Ports:
//   Clock, Clear       - clock; synchronous active-high reset
//   Start              - leaves IDLE
//   MemReady           - memory read data valid (ends the T1 wait)
//   IR                 - instruction word: [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc
//   PCout..LOin        - datapath bus-drive and load strobes
//   Rout / Rin         - one-hot register drive / load selects (Rin bit 0 never set)
//   AluOp              - ALU operation code, valid only in T4
//   Run                - high while executing (not IDLE, not HALTED)
//   InstrCount         - retired-instruction counter, wraps
//   State              - current state encoding for debug
module control_sequencer #(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    Clock,
  input  logic                    Clear,
  input  logic                    Start,
  input  logic                    MemReady,
  input  logic [31:0]             IR,
  output logic                    PCout,
  output logic                    Zlowout,
  output logic                    ZHighout,
  output logic                    MDRout,
  output logic                    MARin,
  output logic                    PCin,
  output logic                    MDRin,
  output logic                    IRin,
  output logic                    Yin,
  output logic                    IncPC,
  output logic                    Read,
  output logic                    ZLowIn,
  output logic                    ZHighIn,
  output logic                    HIin,
  output logic                    LOin,
  output logic [2**ADDR_BITS-1:0] Rout,
  output logic [2**ADDR_BITS-1:0] Rin,
  output logic [4:0]              AluOp,
  output logic                    Run,
  output logic [CNT_W-1:0]        InstrCount,
  output logic [3:0]              State
);

  localparam int unsigned REGS = 2**ADDR_BITS;

  localparam logic [4:0] OP_ALU_MAX = 5'd11;
  localparam logic [4:0] OP_MUL     = 5'd15;
  localparam logic [4:0] OP_DIV     = 5'd16;
  localparam logic [4:0] OP_HALT    = 5'd26;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q;
  logic                   retire_c;

  // Instruction field decode
  logic [4:0]             opcode;
  logic [ADDR_BITS-1:0]   ra, rb, rc;
  logic                   is_alu, is_muldiv, is_halt, is_nop;
  logic [REGS-1:0]        sel_ra, sel_rb, sel_rc;
  logic                   unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26 -: ADDR_BITS];
  assign rb        = IR[22 -: ADDR_BITS];
  assign rc        = IR[18 -: ADDR_BITS];
  assign unused_ir = ^IR[14:0];

  assign is_alu    = (opcode <= OP_ALU_MAX);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_halt   = (opcode == OP_HALT);
  assign is_nop    = !is_alu && !is_muldiv && !is_halt;

  assign sel_ra = REGS'(1) << ra;
  assign sel_rb = REGS'(1) << rb;
  assign sel_rc = REGS'(1) << rc;

  // State register
  always_ff @(posedge Clock) begin
    if (Clear) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Start) state_d = S_T0;
      S_T0:     state_d = S_T1;
      S_T1:     if (MemReady) state_d = S_T2;
      S_T2:     state_d = S_T3;
      S_T3: begin
        if (is_alu || is_muldiv) state_d = S_T4;
        else if (is_halt)        state_d = S_HALTED;
        else                     state_d = S_T0;
      end
      S_T4:     state_d = S_T5;
      S_T5:     state_d = is_muldiv ? S_T6 : S_T0;
      S_T6:     state_d = S_T0;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // An instruction retires on the edge leaving its last execute state
  assign retire_c = ((state_q == S_T3) && is_nop) ||
                    ((state_q == S_T5) && !is_muldiv) ||
                    (state_q == S_T6);

  // Retired-instruction counter
  always_ff @(posedge Clock) begin
    if (Clear)         count_q <= '0;
    else if (retire_c) count_q <= count_q + CNT_W'(1);
  end

  // Output decode; Clear forces every output low in the same cycle
  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    ZHighout   = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    ZLowIn     = 1'b0;
    ZHighIn    = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    Rout       = '0;
    Rin        = '0;
    AluOp      = 5'd0;
    Run        = 1'b0;
    InstrCount = '0;
    State      = 4'd0;
    if (!Clear) begin
      InstrCount = count_q;
      State      = state_q;
      case (state_q)
        S_T0: begin
          Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
        end
        S_T1: begin
          Run = 1'b1; Read = 1'b1; MDRin = 1'b1;
        end
        S_T2: begin
          Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        end
        S_T3: begin
          Run = 1'b1;
          if (is_alu) begin
            Rout = sel_rb; Yin = 1'b1;
          end else if (is_muldiv) begin
            Rout = sel_ra; Yin = 1'b1;
          end
        end
        S_T4: begin
          Run   = 1'b1;
          AluOp = opcode;
          if (is_muldiv) begin
            Rout = sel_rb; ZLowIn = 1'b1; ZHighIn = 1'b1;
          end else begin
            Rout = sel_rc; ZLowIn = 1'b1;
          end
        end
        S_T5: begin
          Run = 1'b1;
          if (is_muldiv) begin
            ZHighout = 1'b1; HIin = 1'b1;
          end else begin
            // R0 is never written: Ra=0 discards the result
            Zlowout = 1'b1;
            if (ra != '0) Rin = sel_ra;
          end
        end
        S_T6: begin
          Run = 1'b1; Zlowout = 1'b1; LOin = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int unsigned CW = 6;

  logic          Clock = 1'b0;
  logic          Clear, Start, MemReady;
  logic [31:0]   IR;
  logic          PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin;
  logic          Yin, IncPC, Read, ZLowIn, ZHighIn, HIin, LOin, Run;
  logic [15:0]   Rout, Rin;
  logic [4:0]    AluOp;
  logic [CW-1:0] InstrCount;
  logic [3:0]    State;

  control_sequencer #(.ADDR_BITS(4), .CNT_W(CW)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .HIin(HIin), .LOin(LOin), .Rout(Rout), .Rin(Rin), .AluOp(AluOp),
    .Run(Run), .InstrCount(InstrCount), .State(State)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic pcout, zlowout, zhighout, mdrout, marin, pcin, mdrin, irin;
    logic yin, incpc, read, zlowin, zhighin, hiin, loin, run;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  aluop;
    logic [3:0]  state;
  } obs_t;

  typedef struct packed {
    obs_t o;
    logic mr;
  } step_t;

  obs_t          obs;
  step_t         seq[$];
  logic [CW-1:0] model_cnt;
  int            n_tests = 0;
  int            n_fail  = 0;

  assign obs = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin,
                Yin, IncPC, Read, ZLowIn, ZHighIn, HIin, LOin, Run,
                Rout, Rin, AluOp, State};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input obs_t o, input logic mr);
    step_t s;
    s.o  = o;
    s.mr = mr;
    seq.push_back(s);
  endtask

  // Reference: expected per-cycle outputs of one instruction, starting at T0.
  // kind: 0 ALU, 1 mul/div, 2 halt, 3 nop
  task automatic build(input logic [31:0] ir, input int waits, output int kind);
    obs_t o;
    int op, ra, rb, rc;
    op = int'(ir[31:27]);
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    if (op <= 11)                kind = 0;
    else if (op == 15 || op == 16) kind = 1;
    else if (op == 26)           kind = 2;
    else                         kind = 3;
    seq.delete();
    o = '0; o.run = 1; o.state = 4'd1;
    o.pcout = 1; o.marin = 1; o.incpc = 1; o.pcin = 1;
    push(o, 1'($urandom));
    for (int w = 0; w <= waits; w++) begin
      o = '0; o.run = 1; o.state = 4'd2; o.read = 1; o.mdrin = 1;
      push(o, w == waits);
    end
    o = '0; o.run = 1; o.state = 4'd3; o.mdrout = 1; o.irin = 1;
    push(o, 1'($urandom));
    o = '0; o.run = 1; o.state = 4'd4;
    if (kind == 0) begin o.rout = 16'(1) << rb; o.yin = 1; end
    if (kind == 1) begin o.rout = 16'(1) << ra; o.yin = 1; end
    push(o, 1'($urandom));
    if (kind <= 1) begin
      o = '0; o.run = 1; o.state = 4'd5; o.aluop = 5'(op); o.zlowin = 1;
      if (kind == 0) o.rout = 16'(1) << rc;
      else begin o.rout = 16'(1) << rb; o.zhighin = 1; end
      push(o, 1'($urandom));
      o = '0; o.run = 1; o.state = 4'd6;
      if (kind == 0) begin
        o.zlowout = 1;
        o.rin = (ra == 0) ? 16'd0 : (16'(1) << ra);
      end else begin
        o.zhighout = 1; o.hiin = 1;
      end
      push(o, 1'($urandom));
      if (kind == 1) begin
        o = '0; o.run = 1; o.state = 4'd7; o.zlowout = 1; o.loin = 1;
        push(o, 1'($urandom));
      end
    end
  endtask

  // Clear (with Start asserted), then verify IDLE holds without Start, then start
  task automatic do_clear();
    Clear = 1; Start = 1; MemReady = 1'($urandom);
    #1 check("clear_zero", {obs, InstrCount}, 64'd0);
    @(negedge Clock);
    Clear = 0; Start = 0; model_cnt = '0;
    #1 check("idle", {obs, InstrCount}, 64'd0);
    @(negedge Clock);
    #1 check("idle_hold", {obs, InstrCount}, 64'd0);
    Start = 1;
    @(negedge Clock);
    Start = 0;
  endtask

  // Run one instruction from T0; abort >= 0 asserts Clear in that cycle index
  task automatic run_instr(input string name, input logic [31:0] ir, input int waits, input int abort);
    int   kind;
    obs_t e;
    logic [CW-1:0] ec;
    build(ir, waits, kind);
    IR = ir;
    for (int i = 0; i < seq.size(); i++) begin
      MemReady = seq[i].mr;
      Start    = 1'($urandom);
      Clear    = (i == abort);
      e  = (i == abort) ? obs_t'(0) : seq[i].o;
      ec = (i == abort) ? CW'(0) : model_cnt;
      #1 check($sformatf("%s c%0d", name, i), {obs, InstrCount}, {e, ec});
      @(negedge Clock);
      if (i == abort) begin
        Clear = 0; Start = 0; model_cnt = '0;
        #1 check($sformatf("%s abort_idle", name), {obs, InstrCount}, 64'd0);
        Start = 1;
        @(negedge Clock);
        Start = 0;
        return;
      end
    end
    if (kind == 2) begin
      for (int k = 0; k < 3; k++) begin
        e = '0; e.state = 4'd8;
        Start = 1; MemReady = 1'($urandom);
        #1 check($sformatf("%s halted%0d", name, k), {obs, InstrCount}, {e, model_cnt});
        @(negedge Clock);
      end
      do_clear();
    end else begin
      model_cnt = model_cnt + CW'(1);
      #1 check($sformatf("%s retire", name), {State, InstrCount}, {4'd1, model_cnt});
    end
  endtask

  initial begin
    logic [31:0] ir;
    logic [4:0]  op;
    Clear = 1; Start = 1; MemReady = 0; IR = '0; model_cnt = '0;
    do_clear();

    run_instr("add", 32'h28918000, 0, -1);
    run_instr("wait3", 32'h28918000, 3, -1);
    run_instr("mul", {5'b01111, 4'd4, 4'd5, 4'd6, 15'd0}, 0, -1);
    run_instr("div", {5'b10000, 4'd9, 4'd15, 4'd0, 15'h1234}, 2, -1);
    run_instr("nop", {5'b11111, 27'h5a5a5a5}, 1, -1);
    run_instr("ra0", {5'd3, 4'd0, 4'd7, 4'd8, 15'd0}, 0, -1);
    run_instr("alu11", {5'd11, 4'd15, 4'd0, 4'd15, 15'd0}, 0, -1);
    run_instr("nop12", {5'd12, 4'd1, 4'd2, 4'd3, 15'd0}, 0, -1);
    run_instr("halt", {5'b11010, 27'd0}, 1, -1);

    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd26) op = 5'd0;
      ir = {op, 27'($urandom)};
      run_instr($sformatf("rnd%0d", n), ir, int'($urandom_range(0, 3)), -1);
    end

    run_instr("abort_t4", 32'h28918000, 1, 5);
    run_instr("abort_t6", {5'b01111, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 6);
    run_instr("after_abort", {5'd7, 4'd2, 4'd3, 4'd4, 15'd0}, 0, -1);

    do_clear();
    for (int n = 0; n < 2**CW; n++) begin
      op = (n % 2 == 0) ? 5'd31 : 5'd20;
      run_instr($sformatf("wrap%0d", n), {op, 27'($urandom)}, 0, -1);
    end
    run_instr("post_wrap", 32'h28918000, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the existing DataPath through instruction fetch and execute, replacing hand-sequenced testbench stimulus. It emits the datapath's out/in strobes, memory read request and ALU operation code from a one-state-per-clock Moore machine. It decodes the IR word presented by the datapath and supports three-register ALU instructions, mul/div with a HI/LO writeback, nop and halt. It sits beside DataPath and memory in the CPU top level.

## Interface
Parameters:
- ADDR_BITS, 4, register-index width (16 registers R0–R15)
- CNT_W, 16, width of InstrCount

Ports:
- Clock  in  1  system clock; all state changes on posedge
- Clear  in  1  reset, synchronous, active-high (one clock; Clear is sampled on the rising edge of Clock)
- Start  in  1  leaves IDLE when high
- MemReady  in  1  memory read data valid on Mdatain
- IR  in  32  datapath IR contents; [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
- PCout, Zlowout, ZHighout, MDRout  out  1 each  bus drive strobes
- MARin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  load/control strobes
- ZLowIn, ZHighIn, HIin, LOin  out  1 each  result register loads
- Rout  out  16  one-hot register drive select
- Rin  out  16  one-hot register load select; bit 0 never asserted
- AluOp  out  5  ALU operation code
- Run  out  1  high in every state except IDLE and HALTED
- InstrCount  out  CNT_W  retired-instruction counter
- State  out  4  current state encoding (debug)

## Operation
- States: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALTED=8. Other encodings → IDLE on the next edge.
- IDLE: all strobes 0. Start=1 → T0.
- T0: PCout, MARin, IncPC, PCin. → T1.
- T1: Read, MDRin held high. MemReady=0 → stay in T1. MemReady=1 → T2; MDR captures in that same cycle.
- T2: MDRout, IRin. → T3. IR is valid from T3 onward.
- T3 decode on IR[31:27]:
  - ALU class 00000–01011: Rout[Rb], Yin. → T4.
  - mul 01111 / div 10000: Rout[Ra], Yin. → T4.
  - halt 11010: no strobes. → HALTED.
  - Any other opcode: treated as nop, no strobes, instruction retires. → T0.
- T4:
  - AluOp = IR[31:27]; AluOp is 0 in every other state.
  - ALU class: Rout[Rc], ZLowIn.
  - mul/div: Rout[Rb], ZLowIn, ZHighIn.
  - → T5.
- T5:
  - ALU class: Zlowout, Rin[Ra]; → T0, instruction retires.
  - mul/div: ZHighout, HIin; → T6.
- T6 (mul/div only): Zlowout, LOin. → T0, instruction retires.
- HALTED: all strobes 0, Run=0. Exited only by Clear.
- Retire: InstrCount increments by 1 on the edge that leaves the final state (T3 for nop, T5 for ALU, T6 for mul/div). It wraps from all-ones to 0. Halt does not count.
- Ra=0 on an ALU op: Rin stays all-zero, so the result is discarded. Rout[0] is permitted.
- Rout and Rin are each either one-hot or zero. They are never asserted in the same cycle.

## Timing
- All outputs are combinational decodes of the state register plus the IR fields, so they are valid the whole cycle.
- Clear high: on that edge State=IDLE and InstrCount=0. Every output is forced to 0 while Clear is high, including Rout=0, Rin=0, AluOp=0 and Run=0.
- Clear overrides Start and MemReady in the same cycle. Clear during any Tn aborts the instruction without retiring it.
- Latency:
  - Fetch: 3 cycles with MemReady already high in T1; each extra wait cycle adds 1.
  - ALU instruction: 6 cycles T0–T5.
  - mul/div: 7 cycles.
  - nop: 4 cycles.
- Start is ignored outside IDLE. The next T0 follows the retiring edge directly, so there are no idle bubbles.
- Read and MDRin drop in the cycle after MemReady is sampled high.

## Test plan
- Clear, then Start: IDLE → T0. T0 shows PCout=MARin=IncPC=PCin=1; Run=1; InstrCount=0.
- IR=0x28918000 (and R1,R2,R3), MemReady high:
  - T3: Rout=0x0004, Yin=1.
  - T4: Rout=0x0008, AluOp=00101, ZLowIn=1.
  - T5: Zlowout=1, Rin=0x0002.
  - Next state T0; InstrCount=1.
- MemReady held low 3 cycles in T1: Read=MDRin=1 for 4 cycles, then T2.
- IR opcode 01111, Ra=4, Rb=5:
  - T3: Rout=0x0010.
  - T4: Rout=0x0020 with ZLowIn=ZHighIn=1.
  - T5: ZHighout and HIin.
  - T6: Zlowout and LOin.
  - InstrCount increments once.
- Opcode 11010: HALTED after T3, Run=0; Start has no effect; Clear returns to IDLE. Opcode 11111: back to T0 after T3, InstrCount+1.
- Clear asserted in T4 of an ALU op: all outputs 0 that cycle, then IDLE, InstrCount=0. Separately, ALU op with Ra=0: Rin=0 in T5. InstrCount preloaded to 0xFFFF wraps to 0 on retire.
